// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit and the ALU control decoder.
package alu_pkg;

  // ALU operation codes, as produced by the ALU control decoder.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MULT = 4'h2;
  localparam logic [3:0] ALU_SLL  = 4'h3;
  localparam logic [3:0] ALU_SLT  = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_SLLI = 4'h9;
  localparam logic [3:0] ALU_SRLI = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;

  // Iterative engine operating modes.
  localparam logic [1:0] ITER_MUL = 2'd0;
  localparam logic [1:0] ITER_SLL = 2'd1;
  localparam logic [1:0] ITER_SRL = 2'd2;

  // Execution unit control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMul   = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath: shift-add multiplier and a one-bit-per-cycle shifter.
// o_done pulses in the cycle of the final iteration; o_result is the value that
// iteration produces, so the owner latches it on the same edge.
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic [DATA_WIDTH-1:0]  i_op_a,
  input  logic [DATA_WIDTH-1:0]  i_op_b,
  input  logic [SHAMT_WIDTH-1:0] i_amount,
  output logic                   o_done,
  output logic [DATA_WIDTH-1:0]  o_result
);

  // One extra bit so the counter can hold DATA_WIDTH itself.
  localparam int unsigned CntWidth = SHAMT_WIDTH + 1;

  logic                  busy_q;
  logic [1:0]            mode_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] acc_step;
  logic                  last_iter;

  // Value of the accumulator after the current iteration.
  always_comb begin
    acc_step = acc_q;
    case (mode_q)
      ITER_MUL: acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
      ITER_SLL: acc_step = acc_q << 1;
      ITER_SRL: acc_step = acc_q >> 1;
      default:  acc_step = acc_q;
    endcase
  end

  assign last_iter = busy_q && (cnt_q == CntWidth'(1));
  assign o_done    = last_iter;
  assign o_result  = acc_step;

  // Operand load on start, then one iteration per cycle until the count expires.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_q   <= 1'b0;
      mode_q   <= ITER_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (i_start) begin
      busy_q   <= 1'b1;
      mode_q   <= i_mode;
      cnt_q    <= (i_mode == ITER_MUL) ? CntWidth'(DATA_WIDTH) : {1'b0, i_amount};
      acc_q    <= (i_mode == ITER_MUL) ? '0 : i_op_a;
      mcand_q  <= i_op_a;
      mplier_q <= i_op_b;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CntWidth'(1);
      if (last_iter) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU execution unit behind valid/ready handshakes. Single-cycle ops
// resolve at the accept edge; multiply and non-zero shifts run in the engine.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [3:0]             i_alu_operation,
  input  logic [DATA_WIDTH-1:0]  i_op_a,
  input  logic [DATA_WIDTH-1:0]  i_op_b,
  input  logic [SHAMT_WIDTH-1:0] i_shamt,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_result,
  output logic                   o_zero,
  output logic                   o_illegal
);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0]  single_res;
  logic                   is_illegal;
  logic                   is_mul;
  logic                   is_shift;
  logic                   shift_left;
  logic [SHAMT_WIDTH-1:0] amount;
  logic [1:0]             eng_mode;
  logic                   eng_start;
  logic                   eng_done;
  logic [DATA_WIDTH-1:0]  eng_result;

  // Decode the request and compute every single-cycle result from the live inputs.
  always_comb begin
    single_res = '0;
    is_illegal = 1'b0;
    is_mul     = 1'b0;
    is_shift   = 1'b0;
    shift_left = 1'b0;
    amount     = i_op_b[SHAMT_WIDTH-1:0];
    case (i_alu_operation)
      ALU_ADD:  single_res = i_op_a + i_op_b;
      ALU_SUB:  single_res = i_op_a - i_op_b;
      ALU_MULT: is_mul = 1'b1;
      ALU_SLL: begin
        is_shift   = 1'b1;
        shift_left = 1'b1;
      end
      ALU_SLT:  single_res = DATA_WIDTH'($signed(i_op_a) < $signed(i_op_b));
      ALU_XOR:  single_res = i_op_a ^ i_op_b;
      ALU_SRL:  is_shift = 1'b1;
      ALU_OR:   single_res = i_op_a | i_op_b;
      ALU_AND:  single_res = i_op_a & i_op_b;
      ALU_SLLI: begin
        is_shift   = 1'b1;
        shift_left = 1'b1;
        amount     = i_shamt;
      end
      ALU_SRLI: begin
        is_shift = 1'b1;
        amount   = i_shamt;
      end
      ALU_LUI:  single_res = i_op_b << (DATA_WIDTH / 2);
      default:  is_illegal = 1'b1;
    endcase
    // A zero-length shift is just a pass-through and completes immediately.
    if (is_shift) begin
      single_res = i_op_a;
    end
  end

  always_comb begin
    eng_mode = ITER_MUL;
    if (!is_mul) begin
      eng_mode = shift_left ? ITER_SLL : ITER_SRL;
    end
  end

  alu_iter_engine #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_iter_engine (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (eng_start),
    .i_mode   (eng_mode),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .i_amount (amount),
    .o_done   (eng_done),
    .o_result (eng_result)
  );

  // Next-state and output-register updates for the control FSM.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    eng_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          illegal_d = is_illegal;
          if (is_mul) begin
            state_d   = StMul;
            eng_start = 1'b1;
          end else if (is_shift && (amount != '0)) begin
            state_d   = StShift;
            eng_start = 1'b1;
          end else begin
            state_d  = StDone;
            result_d = single_res;
            zero_d   = (single_res == '0);
          end
        end
      end
      StMul, StShift: begin
        if (eng_done) begin
          state_d  = StDone;
          result_d = eng_result;
          zero_d   = (eng_result == '0);
        end
      end
      StDone: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset also aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_result  = result_q;
  assign o_zero    = zero_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    i_alu_operation;
  logic [DW-1:0] i_op_a;
  logic [DW-1:0] i_op_b;
  logic [SW-1:0] i_shamt;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_result;
  logic          o_zero;
  logic          o_illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(
    .DATA_WIDTH  (DW),
    .SHAMT_WIDTH (SW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_alu_operation (i_alu_operation),
    .i_op_a          (i_op_a),
    .i_op_b          (i_op_b),
    .i_shamt         (i_shamt),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_result        (o_result),
    .o_zero          (o_zero),
    .o_illegal       (o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request, wait (bounded) for o_valid, check result and latency.
  // With fin set, the result is consumed and the return to idle is checked.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [SW-1:0] sh,
                        input logic [DW-1:0] exp_res, input logic exp_zero,
                        input logic exp_ill, input int exp_lat, input bit fin);
    int  cyc;
    bit  ready_seen;
    @(negedge i_clk);
    i_valid         = 1'b1;
    i_alu_operation = op;
    i_op_a          = a;
    i_op_b          = b;
    i_shamt         = sh;
    @(posedge i_clk);
    #1;
    i_valid         = 1'b0;
    i_op_a          = '0;
    i_op_b          = '0;
    i_shamt         = '0;
    cyc        = 1;
    ready_seen = o_ready;
    while (!o_valid && cyc < 100) begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_ready) ready_seen = 1'b1;
    end
    chk({tag, "_latency"}, DW'(cyc), DW'(exp_lat));
    chk({tag, "_result"}, o_result, exp_res);
    chk({tag, "_zero"}, DW'(o_zero), DW'(exp_zero));
    chk({tag, "_illegal"}, DW'(o_illegal), DW'(exp_ill));
    chk({tag, "_ready_busy"}, DW'(ready_seen), '0);
    if (fin) begin
      @(posedge i_clk);
      #1;
      chk({tag, "_valid_drop"}, DW'(o_valid), '0);
      chk({tag, "_ready_back"}, DW'(o_ready), 32'd1);
    end
  endtask

  initial begin
    i_rst_n         = 1'b0;
    i_valid         = 1'b0;
    i_ready         = 1'b1;
    i_alu_operation = '0;
    i_op_a          = '0;
    i_op_b          = '0;
    i_shamt         = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", DW'(o_valid), '0);
    chk("rst_ready", DW'(o_ready), 32'd1);
    chk("rst_result", o_result, '0);
    chk("rst_zero", DW'(o_zero), '0);
    chk("rst_illegal", DW'(o_illegal), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("add", 4'h0, 32'd5, 32'd7, '0, 32'd12, 1'b0, 1'b0, 1, 1'b1);
    run_op("sub", 4'h1, 32'd7, 32'd7, '0, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    run_op("mul_ffff", 4'h2, 32'h0000FFFF, 32'h00010001, '0, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 1'b1);
    run_op("mul_wrap", 4'h2, 32'h80000000, 32'd2, '0, 32'd0, 1'b1, 1'b0, 33, 1'b1);
    run_op("sll", 4'h3, 32'd1, 32'h00000023, '0, 32'd8, 1'b0, 1'b0, 4, 1'b1);
    run_op("srl_hibits", 4'h6, 32'h000000F0, 32'hFFFFFFE4, '0, 32'h0000000F, 1'b0, 1'b0, 5, 1'b1);
    run_op("srli31", 4'hA, 32'h80000000, 32'hFFFFFFFF, 5'd31, 32'd1, 1'b0, 1'b0, 32, 1'b1);
    run_op("slli0", 4'h9, 32'h0000ABCD, 32'h0000001F, 5'd0, 32'h0000ABCD, 1'b0, 1'b0, 1, 1'b1);
    run_op("slt_neg", 4'h4, 32'hFFFFFFFF, 32'd1, '0, 32'd1, 1'b0, 1'b0, 1, 1'b1);
    run_op("slt_swap", 4'h4, 32'd1, 32'hFFFFFFFF, '0, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    run_op("lui", 4'hB, 32'hDEADBEEF, 32'h00001234, '0, 32'h12340000, 1'b0, 1'b0, 1, 1'b1);
    run_op("or", 4'h7, 32'h000000F0, 32'h0000000F, '0, 32'h000000FF, 1'b0, 1'b0, 1, 1'b1);
    run_op("and", 4'h8, 32'h000000F0, 32'h0000003C, '0, 32'h00000030, 1'b0, 1'b0, 1, 1'b1);

    // Backpressure: result must hold while the consumer stalls.
    @(negedge i_clk);
    i_ready = 1'b0;
    run_op("xor", 4'h5, 32'h0000F0F0, 32'h00000FF0, '0, 32'h0000FF00, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      chk("bp_valid", DW'(o_valid), 32'd1);
      chk("bp_result", o_result, 32'h0000FF00);
      chk("bp_ready", DW'(o_ready), '0);
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("bp_release_ready", DW'(o_ready), 32'd1);
    chk("bp_release_valid", DW'(o_valid), '0);

    // Reset in the middle of a multiply.
    @(negedge i_clk);
    i_valid         = 1'b1;
    i_alu_operation = 4'h2;
    i_op_a          = 32'h00000003;
    i_op_b          = 32'h00000005;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    chk("abort_valid", DW'(o_valid), '0);
    chk("abort_ready", DW'(o_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // No stale multiply result may surface after the abort.
    repeat (30) @(posedge i_clk);
    #1;
    chk("abort_no_late_valid", DW'(o_valid), '0);
    run_op("add_after_rst", 4'h0, 32'd2, 32'd3, '0, 32'd5, 1'b0, 1'b0, 1, 1'b1);

    // Illegal opcode, then a legal accept clears the flag.
    run_op("illegal_d", 4'hD, 32'h12345678, 32'h9ABCDEF0, '0, 32'd0, 1'b1, 1'b1, 1, 1'b1);
    chk("illegal_held", DW'(o_illegal), 32'd1);
    run_op("illegal_f", 4'hF, 32'd1, 32'd1, '0, 32'd0, 1'b1, 1'b1, 1, 1'b1);
    run_op("clear_ill", 4'h0, 32'd1, 32'd1, '0, 32'd2, 1'b0, 1'b0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
